l2_l3_line_master: RTL and testbench
====================================

// Module: l2_l3_line_master
// PURPOSE
//  L2-side initiator for the L3 slice word interface. Accepts one line-level miss (refill read or
//  writeback) from the L2 controller and splits it into LINE_WORDS sequential 64-bit L3 requests.
//  Collects each L3 response, assembles refill data, and returns one completion to L2.
//  One line in flight at a time; one L3 word request outstanding at a time.
// PARAMETERS
//  LINE_WORDS   8   64-bit words per line (power of 2, >=2); OFF = log2(LINE_WORDS)+3 offset bits
//  TIMEOUT_CYC  16  max WAIT cycles per word before abort (>=2)
// PORTS
//  clk              in   1              clock
//  rst_n            in   1              synchronous active-low reset
//  miss_valid_i     in   1              L2 line request valid
//  miss_ready_o     out  1              block idle, can accept request
//  miss_addr_i      in   64             line address; bits [OFF-1:0] ignored
//  miss_write_i     in   1              1 = writeback, 0 = refill read
//  miss_wdata_i     in   64*LINE_WORDS  writeback line; word k at [k*64 +: 64]
//  done_valid_o     out  1              completion valid
//  done_ready_i     in   1              L2 accepts completion
//  done_rdata_o     out  64*LINE_WORDS  refill line (0 for writeback or error)
//  done_err_o       out  1              line aborted on timeout
//  l3_req_valid_o   out  1              L3 word request valid
//  l3_req_addr_o    out  64             L3 word address
//  l3_req_write_o   out  1              L3 write
//  l3_req_wdata_o   out  64             L3 write data
//  l3_resp_ready_o  out  1              master ready for L3 response
//  l3_resp_valid_i  in   1              L3 response valid (one-cycle pulse)
//  l3_resp_rdata_i  in   64             L3 read data (don't-care for writes)
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE, idx=0, timer=0, line buffer and done_err cleared.
//    All outputs are 0 while rst_n=0 (miss_ready_o gated by rst_n); miss_ready_o=1 from first cycle after.
//  - L3 protocol: the slice samples a request only at a posedge where req_valid && resp_ready are both 1, and
//    pulses resp_valid on the following cycle. There is no req_ready. The master drives
//    l3_req_valid_o=1 for exactly one cycle per word (ISSUE); l3_resp_ready_o=1 in ISSUE and WAIT.
//  - FSM:
//    IDLE : miss_ready_o=1. On miss_valid_i: latch addr/write/wdata, idx=0 -> ISSUE.
//    ISSUE: l3_req_valid_o=1, addr={line[63:OFF], idx, 3'b000}, write=latched, wdata=word idx.
//           Timer cleared -> WAIT. l3_resp_valid_i here is ignored.
//    WAIT : On l3_resp_valid_i: on a read, store rdata into word idx.
//           If idx==LINE_WORDS-1 -> DONE, else idx++ -> ISSUE. Otherwise timer++.
//           Timer==TIMEOUT_CYC-1 with no resp -> DONE, done_err_o=1, line buffer zeroed.
//    DONE : done_valid_o=1; rdata/err held stable until done_ready_i -> IDLE (buffer, err cleared).
//  - miss_valid_i is ignored outside IDLE. A new miss is accepted no earlier than the cycle after done handshake.
//  - l3_resp_valid_i in IDLE or DONE: ignored, no state change.
//  - Latency: handshake at cycle 0 -> ISSUE w0 at cycle 1. With a registered 1-cycle slice each word takes 2 cycles.
//    done_valid_o rises in cycle 2*LINE_WORDS+1 (17 for default).
//  - Idx wraps never: its width is log2(LINE_WORDS), and the last word is detected by compare, not overflow.
//  - Writeback done_rdata_o is all-zero; the write responses serve as acks only.
//  - Reset mid-line: abandon immediately. No L3 request is issued after reset; late resp pulses are ignored.
// TESTING
//  1. Read miss 0x0000_0000_0000_1040 (low bits 0x07 set, ignored); L3 returns word k=0xA000+k ->
//     L3 addrs 0x1040..0x1078 step 8, done at cycle 17, word k = 0xA000+k, err=0.
//  2. Writeback miss addr 0x2000, word k=0xB0+k -> 8 L3 writes (write=1, wdata=0xB0+k).
//     done_rdata_o=0, done_err_o=0.
//  3. Timeout: L3 stalls on word 3 -> after 16 WAIT cycles done_valid_o=1, done_err_o=1, done_rdata_o=0.
//     No word-4 request.
//  4. Back-pressure: hold done_ready_i=0 for 5 cycles -> done outputs stable, miss_valid_i ignored.
//     miss_ready_o=1 the cycle after done_ready_i=1.
//  5. Reset at cycle 6 of a read -> next cycle IDLE, all outputs 0 during reset, spurious resp pulse ignored.
//     Next miss completes normally.
//  6. Spurious l3_resp_valid_i in IDLE and in ISSUE -> no state/idx change, data unaffected.

Source files
------------

// File: rtl/l2_l3_line_master.sv
// L2-side line master: splits one line miss into LINE_WORDS sequential 64-bit L3 word
// requests, gathers refill data and returns a single completion (with timeout abort).
module l2_l3_line_master #(
  parameter int unsigned LINE_WORDS  = 8,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       miss_valid_i,
  output logic                       miss_ready_o,
  input  logic [63:0]                miss_addr_i,
  input  logic                       miss_write_i,
  input  logic [64*LINE_WORDS-1:0]   miss_wdata_i,
  output logic                       done_valid_o,
  input  logic                       done_ready_i,
  output logic [64*LINE_WORDS-1:0]   done_rdata_o,
  output logic                       done_err_o,
  output logic                       l3_req_valid_o,
  output logic [63:0]                l3_req_addr_o,
  output logic                       l3_req_write_o,
  output logic [63:0]                l3_req_wdata_o,
  output logic                       l3_resp_ready_o,
  input  logic                       l3_resp_valid_i,
  input  logic [63:0]                l3_resp_rdata_i
);
  localparam int unsigned IDX_W  = $clog2(LINE_WORDS);
  localparam int unsigned OFF    = IDX_W + 3;
  localparam int unsigned TMR_W  = $clog2(TIMEOUT_CYC);
  localparam int unsigned LINE_W = 64 * LINE_WORDS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic [TMR_W-1:0]    timer;
  logic [63-OFF:0]     tag;
  logic                write_q;
  logic [LINE_W-1:0]   wdata_q;
  logic [LINE_W-1:0]   rdata_q;
  logic                err_q;
  logic                unused_low;

  // Line offset bits of the miss address carry no information.
  assign unused_low = ^miss_addr_i[OFF-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      timer   <= '0;
      tag     <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_valid_i) begin
            tag     <= miss_addr_i[63:OFF];
            write_q <= miss_write_i;
            wdata_q <= miss_wdata_i;
            idx     <= '0;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (l3_resp_valid_i) begin
            if (!write_q) rdata_q[{idx, 6'b0} +: 64] <= l3_resp_rdata_i;
            if (idx == LAST_IDX) begin
              state <= DONE;
            end else begin
              idx   <= idx + IDX_W'(1);
              state <= ISSUE;
            end
          end else if (timer == TMR_MAX) begin
            // Abort: partial refill data is never returned.
            rdata_q <= '0;
            err_q   <= 1'b1;
            state   <= DONE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        DONE: begin
          if (done_ready_i) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode registered state; forced low while reset is asserted.
  assign miss_ready_o    = rst_n && (state == IDLE);
  assign l3_req_valid_o  = rst_n && (state == ISSUE);
  assign l3_resp_ready_o = rst_n && ((state == ISSUE) || (state == WAIT));
  assign l3_req_addr_o   = rst_n ? {tag, idx, 3'b000} : 64'd0;
  assign l3_req_write_o  = rst_n && write_q;
  assign l3_req_wdata_o  = rst_n ? wdata_q[{idx, 6'b0} +: 64] : 64'd0;
  assign done_valid_o    = rst_n && (state == DONE);
  assign done_rdata_o    = rst_n ? rdata_q : LINE_W'(0);
  assign done_err_o      = rst_n && err_q;

endmodule

// File: tb/tb_l2_l3_line_master.sv
// Scoreboard bench for l2_l3_line_master: expected L3 requests and completions are queued at
// stimulus time and checked by a negedge monitor; a behavioural L3 slice answers requests.
module tb_l2_l3_line_master;
  typedef struct packed {
    logic [63:0] addr;
    logic        write;
    logic [63:0] wdata;
  } req_t;

  typedef struct packed {
    logic [511:0] rdata;
    logic         err;
    logic [31:0]  lat;
  } comp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         miss_valid = 1'b0;
  logic         miss_ready;
  logic [63:0]  miss_addr = '0;
  logic         miss_write = 1'b0;
  logic [511:0] miss_wdata = '0;
  logic         done_valid;
  logic         done_ready = 1'b1;
  logic [511:0] done_rdata;
  logic         done_err;
  logic         l3_req_valid;
  logic [63:0]  l3_req_addr;
  logic         l3_req_write;
  logic [63:0]  l3_req_wdata;
  logic         l3_resp_ready;
  logic         l3_resp_valid = 1'b0;
  logic [63:0]  l3_resp_rdata = '0;

  int nchk = 0;
  int nfail = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rise_cyc = 0;
  logic done_prev = 1'b0;

  req_t  req_q[$];
  comp_t comp_q[$];

  // slice controls
  logic [63:0] slice_base = '0;
  logic        stall_en = 1'b0;
  logic [2:0]  stall_k = '0;
  logic        inject_idle = 1'b0;
  logic        inject_issue = 1'b0;
  logic [2:0]  inject_k = '0;
  logic        pend = 1'b0;
  logic [2:0]  pend_k = '0;

  l2_l3_line_master dut (
    .clk(clk), .rst_n(rst_n),
    .miss_valid_i(miss_valid), .miss_ready_o(miss_ready), .miss_addr_i(miss_addr),
    .miss_write_i(miss_write), .miss_wdata_i(miss_wdata),
    .done_valid_o(done_valid), .done_ready_i(done_ready), .done_rdata_o(done_rdata),
    .done_err_o(done_err),
    .l3_req_valid_o(l3_req_valid), .l3_req_addr_o(l3_req_addr), .l3_req_write_o(l3_req_write),
    .l3_req_wdata_o(l3_req_wdata), .l3_resp_ready_o(l3_resp_ready),
    .l3_resp_valid_i(l3_resp_valid), .l3_resp_rdata_i(l3_resp_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] line_of(input logic [63:0] base);
    logic [511:0] r;
    for (int k = 0; k < 8; k++) r[k*64 +: 64] = base + 64'(k);
    return r;
  endfunction

  // L3 slice: a request seen in one cycle is answered with a pulse during the next cycle.
  always @(negedge clk) begin
    l3_resp_valid = 1'b0;
    if (pend) begin
      l3_resp_valid = 1'b1;
      l3_resp_rdata = slice_base + 64'(pend_k);
    end
    if (inject_idle) begin
      l3_resp_valid = 1'b1;
      l3_resp_rdata = 64'hDEAD_DEAD;
    end
    if (inject_issue && l3_req_valid && l3_req_addr[5:3] == inject_k) begin
      l3_resp_valid = 1'b1;
      l3_resp_rdata = 64'hDEAD_BEEF;
    end
    pend   = l3_req_valid && l3_resp_ready && !(stall_en && l3_req_addr[5:3] == stall_k);
    pend_k = l3_req_addr[5:3];
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    req_t  r;
    comp_t c;
    if (rst_n && miss_valid && miss_ready) start_cyc = cyc;
    if (done_valid && !done_prev) rise_cyc = cyc;
    done_prev = done_valid;
    if (l3_req_valid) begin
      if (req_q.size() == 0) begin
        nchk++; nfail++;
        $display("FAIL unexpected_l3_req got addr=%0h exp=none", l3_req_addr);
      end else begin
        r = req_q.pop_front();
        check("l3_req_addr", l3_req_addr, r.addr);
        check("l3_req_write", l3_req_write, r.write);
        if (r.write) check("l3_req_wdata", l3_req_wdata, r.wdata);
      end
    end
    if (done_valid && done_ready) begin
      if (comp_q.size() == 0) begin
        nchk++; nfail++;
        $display("FAIL unexpected_done got err=%0b exp=none", done_err);
      end else begin
        c = comp_q.pop_front();
        check("done_rdata", done_rdata, c.rdata);
        check("done_err", done_err, c.err);
        if (c.lat != 32'hFFFF_FFFF) check("done_latency", rise_cyc - start_cyc, c.lat);
      end
    end
  end

  // Queue expectations and hand one miss to the DUT (returns in cycle 1 of the line).
  task automatic start_line(input logic [63:0] addr, input logic wr, input logic [63:0] base,
                            input int last_word, input logic err, input int lat, input logic push_comp);
    req_t  r;
    comp_t c;
    for (int k = 0; k <= last_word; k++) begin
      r.addr  = {addr[63:6], 3'(k), 3'b000};
      r.write = wr;
      r.wdata = base + 64'(k);
      req_q.push_back(r);
    end
    if (push_comp) begin
      c.rdata = (wr || err) ? 512'd0 : line_of(base);
      c.err   = err;
      c.lat   = 32'(lat);
      comp_q.push_back(c);
    end
    slice_base = base;
    miss_addr  = addr;
    miss_write = wr;
    miss_wdata = line_of(base);
    miss_valid = 1'b1;
    tick();
    miss_valid = 1'b0;
  endtask

  task automatic wait_comp();
    int n = 0;
    while (comp_q.size() > 0 && n < 200) begin
      tick();
      n++;
    end
    if (comp_q.size() > 0) begin
      nchk++; nfail++;
      $display("FAIL completion_timeout got pending=%0d exp=0", comp_q.size());
      comp_q.delete();
      req_q.delete();
    end
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_miss_ready"}, miss_ready, 0);
    check({tag, "_l3_req_valid"}, l3_req_valid, 0);
    check({tag, "_l3_resp_ready"}, l3_resp_ready, 0);
    check({tag, "_l3_req_addr"}, l3_req_addr, 0);
    check({tag, "_done_valid"}, done_valid, 0);
    check({tag, "_done_err"}, done_err, 0);
    check({tag, "_done_rdata"}, done_rdata, 0);
  endtask

  initial begin
    int n;
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    tick();
    rst_n = 1'b1;
    #1;
    check("post_reset_miss_ready", miss_ready, 1);
    tick();

    // 1: refill read, offset bits ignored
    start_line(64'h1047, 1'b0, 64'hA000, 7, 1'b0, 17, 1'b1);
    wait_comp();

    // 2: writeback
    start_line(64'h2000, 1'b1, 64'hB0, 7, 1'b0, 17, 1'b1);
    wait_comp();

    // 3: timeout on word 3, no word-4 request
    stall_en = 1'b1;
    stall_k  = 3'd3;
    start_line(64'h3000, 1'b0, 64'h1100, 3, 1'b1, 24, 1'b1);
    wait_comp();
    stall_en = 1'b0;
    check("timeout_req_queue_empty", req_q.size(), 0);

    // 4: done back-pressure
    done_ready = 1'b0;
    start_line(64'h4000, 1'b0, 64'h7000, 7, 1'b0, 17, 1'b1);
    n = 0;
    while (!done_valid && n < 100) begin
      tick();
      n++;
    end
    check("bp_done_seen", done_valid, 1);
    miss_valid = 1'b1;
    miss_addr  = 64'h9000;
    repeat (5) begin
      tick();
      check("bp_done_valid_held", done_valid, 1);
      check("bp_rdata_held", done_rdata, line_of(64'h7000));
      check("bp_miss_ready", miss_ready, 0);
    end
    miss_valid = 1'b0;
    done_ready = 1'b1;
    tick();
    check("bp_miss_ready_after", miss_ready, 1);
    check("bp_comp_popped", comp_q.size(), 0);
    tick();

    // 5: reset in cycle 6 of a read
    start_line(64'h5000, 1'b0, 64'h3300, 2, 1'b0, 0, 1'b0);
    repeat (5) tick();
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    tick();
    rst_n = 1'b1;
    #1;
    check("midreset_miss_ready", miss_ready, 1);
    check("midreset_req_valid", l3_req_valid, 0);
    check("midreset_reqs_issued", req_q.size(), 0);
    tick();
    start_line(64'h5800, 1'b0, 64'h4400, 7, 1'b0, 17, 1'b1);
    wait_comp();

    // 6: spurious responses in IDLE and ISSUE
    inject_idle = 1'b1;
    tick();
    inject_idle = 1'b0;
    tick();
    check("spurious_idle_ready", miss_ready, 1);
    check("spurious_idle_no_done", done_valid, 0);
    inject_issue = 1'b1;
    inject_k     = 3'd2;
    start_line(64'h6000, 1'b0, 64'hC000, 7, 1'b0, 17, 1'b1);
    wait_comp();
    inject_issue = 1'b0;

    $display("[TB] %0d tests run, %0d failed", nchk, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end
endmodule
